otprom_ctrl: RTL and testbench
==============================

// Module: otprom_ctrl
// PURPOSE
//  Sole owner of the OTPROM macro port. Sits between the CPU master port and the OTPROM.
//  After reset it shadow-loads CFG_WORDS fuse words into sticky config registers.
//  It then passes CPU reads through and serialises all burns through a timed program/verify sequencer.
//  Bit semantics: unburned=0, burned=1; burns can only set bits.
// PARAMETERS
//  CFG_BASE   'h10  word address of first config fuse word
//  CFG_WORDS  4     config words shadow-loaded at boot (1..16)
//  RD_LAT     1     OTPROM read latency in cycles (rdata valid RD_LAT cycles after ren)
//  PGM_PULSE  8     cycles s_ram_wen held asserted per burn (>=1)
// PORTS
//  clk          in   1                clock
//  resetn       in   1                synchronous active-low reset
//  m_ram_raddr  in   BUS_WIDTH        CPU read address
//  m_ram_ren    in   1                CPU read enable; held until m_ram_ready=1
//  m_ram_rdata  out  DATA_WIDTH       CPU read data (= s_ram_rdata)
//  m_ram_ready  out  1                CPU read accepted this cycle
//  pgm_req      in   1                1-cycle burn request pulse
//  pgm_addr     in   BUS_WIDTH        burn word address, sampled with pgm_req
//  pgm_data     in   DATA_WIDTH       bits to burn (1=burn), sampled with pgm_req
//  pgm_busy     out  1                sequencer not IDLE
//  pgm_done     out  1                1-cycle pulse: burn finished or rejected
//  pgm_err      out  1                valid with pgm_done: rejected or verify mismatch
//  s_ram_raddr  out  BUS_WIDTH        OTPROM read address
//  s_ram_ren    out  1                OTPROM read enable
//  s_ram_rdata  in   DATA_WIDTH       OTPROM read data
//  s_ram_waddr  out  BUS_WIDTH        OTPROM burn address
//  s_ram_wdata  out  DATA_WIDTH       OTPROM burn data
//  s_ram_wen    out  DATA_WIDTH/8     OTPROM burn strobe (all ones while burning)
//  cfg_valid    out  1                shadow load complete (sticky until reset)
//  cfg_word     out  CFG_WORDS*DATA_WIDTH  shadow fuse words, word0 in LSBs
//  secure_debug_disable out 1         = cfg_word0[0]
//  pgm_lock     out  1                = cfg_word0[1]
// BEHAVIOUR
//  Reset values: state=LD_ISSUE, word idx=0, cfg_word=0, cfg_valid=0,
//   secure_debug_disable=0, pgm_lock=0, pgm_busy=1, pgm_done=0, pgm_err=0.
//  Reset while resetn=0: s_ram_wen=0 combinationally; a burn pulse in progress ends immediately.
//  Any reset mid-sequence aborts it; no pgm_done is issued.
//  States:
//   LD_ISSUE: s_ram_ren=1, raddr=CFG_BASE+idx; next LD_WAIT.
//   LD_WAIT: RD_LAT cycles; on the last one capture s_ram_rdata into cfg_word[idx].
//    If idx=CFG_WORDS-1: go IDLE, set cfg_valid. Else idx++ and go LD_ISSUE.
//   Load latency: cfg_valid rises CFG_WORDS*(1+RD_LAT) cycles after the first resetn=1 edge (8 at defaults).
//   IDLE: s_ram_raddr=m_ram_raddr, s_ram_ren=m_ram_ren, m_ram_ready=1, pgm_busy=0.
//    pgm_req with (pgm_lock|~cfg_valid): next cycle pgm_done=1, pgm_err=1, no OTPROM write; stay IDLE.
//    pgm_req otherwise: latch addr/data; go PGM_WR.
//   PGM_WR: s_ram_wen=all ones, waddr/wdata=latched values, for exactly PGM_PULSE cycles; next VF_ISSUE.
//   VF_ISSUE: one read of the latched addr.
//   VF_WAIT: RD_LAT cycles; on the last one compare (rdata & data)==data. Next cycle pgm_done=1,
//    pgm_err=~match, return IDLE.
//  Outside IDLE: m_ram_ready=0, s_ram_ren driven only by the controller.
//  m_ram_wen is not a port: CPU cannot write the OTPROM directly.
//  Shadow registers are never updated after load; a burn to a cfg address takes effect only after reset.
//  A CPU read and pgm_req in the same IDLE cycle: the read completes that cycle, the burn is accepted.
//  pgm_req while pgm_busy=1 is dropped silently (no pgm_done).
//  Address arithmetic: CFG_BASE+idx is computed in BUS_WIDTH and wraps modulo 2^BUS_WIDTH.
//  s_ram_wen=0 in every state except PGM_WR.
// STRUCTURE
//  defines.vh (shared): OTPC_ST_* state encodings, OTP_CFG_SDD_BIT=0, OTP_CFG_LOCK_BIT=1.
//  BUS_WIDTH/DATA_WIDTH also come from defines.vh.
//  Sub-module otprom_ctrl_timer: loadable down-counter serving RD_LAT and PGM_PULSE waits, zero flag out.
//  All flops use dffrl_s/dffrle_s; state register one-hot or binary per OTPC_ST_*.
// TESTING
//  1. Model cfg words {'h1,'h0,'hA5,'h3C}, release reset -> ren at addr 'h10..'h13.
//     cfg_valid high at cycle 8; secure_debug_disable=1; cfg_word matches the model.
//  2. CPU read 'h40 held from cycle 2 -> m_ram_ready=0 until IDLE; accepted first IDLE cycle; rdata = model['h40].
//  3. pgm_req addr 'h20 data 'h0F, model stores burns -> s_ram_wen='1 for exactly 8 cycles, then 1 read.
//     pgm_done with pgm_err=0, 11 cycles after req.
//  4. Model ignores burn of bit 2 -> pgm_done with pgm_err=1; pgm_busy falls in the same cycle.
//  5. Word0='h2 (lock) -> pgm_req gives pgm_done+pgm_err next cycle, s_ram_wen never asserted.
//  6. resetn low at the 3rd PGM_WR cycle -> s_ram_wen=0 that cycle, no pgm_done.
//     Full reload follows, cfg_word reflects any partial burn.

Source files
------------

// File: rtl/otprom_ctrl_pkg.sv
// Shared definitions for the OTPROM controller: bus/data widths, config fuse bit
// positions and the sequencer state encoding.
package otprom_ctrl_pkg;

    localparam int unsigned BUS_WIDTH  = 10;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned WEN_WIDTH  = DATA_WIDTH / 8;

    // Bit positions inside config word 0.
    localparam int unsigned OTP_CFG_SDD_BIT  = 0;
    localparam int unsigned OTP_CFG_LOCK_BIT = 1;

    typedef enum logic [2:0] {
        StLdIssue = 3'd0,
        StLdWait  = 3'd1,
        StIdle    = 3'd2,
        StPgmWr   = 3'd3,
        StVfIssue = 3'd4,
        StVfWait  = 3'd5
    } otpc_state_e;

endpackage

// File: rtl/otprom_ctrl_timer.sv
// Loadable down-counter used for the read-latency and program-pulse waits.
// Ports:
//   clk_i      clock
//   rst_ni     synchronous active-low reset
//   load_i     load load_val_i this cycle (takes priority over counting)
//   load_val_i value loaded; zero_o rises load_val_i cycles after the load
//   zero_o     counter is at zero
module otprom_ctrl_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/otprom_ctrl.sv
// OTPROM controller: sole owner of the OTPROM macro port. After reset it shadow-loads
// CFG_WORDS fuse words into sticky config registers, then passes CPU reads through and
// serialises burns through a timed program/verify sequence.
// Ports:
//   clk, resetn                     clock, synchronous active-low reset
//   m_ram_*                         CPU read port (ready only while idle)
//   pgm_req/addr/data               burn request (1-cycle pulse, sampled in idle)
//   pgm_busy/done/err               sequencer status; done is a 1-cycle pulse, err valid with it
//   s_ram_*                         OTPROM macro read and burn port
//   cfg_valid, cfg_word             shadow load complete, shadow words (word0 in LSBs)
//   secure_debug_disable, pgm_lock  decoded bits of config word 0
module otprom_ctrl
    import otprom_ctrl_pkg::*;
#(
    parameter logic [BUS_WIDTH-1:0] CFG_BASE  = BUS_WIDTH'('h10),
    parameter int unsigned          CFG_WORDS = 4,
    parameter int unsigned          RD_LAT    = 1,
    parameter int unsigned          PGM_PULSE = 8
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [BUS_WIDTH-1:0]            m_ram_raddr,
    input  logic                            m_ram_ren,
    output logic [DATA_WIDTH-1:0]           m_ram_rdata,
    output logic                            m_ram_ready,
    input  logic                            pgm_req,
    input  logic [BUS_WIDTH-1:0]            pgm_addr,
    input  logic [DATA_WIDTH-1:0]           pgm_data,
    output logic                            pgm_busy,
    output logic                            pgm_done,
    output logic                            pgm_err,
    output logic [BUS_WIDTH-1:0]            s_ram_raddr,
    output logic                            s_ram_ren,
    input  logic [DATA_WIDTH-1:0]           s_ram_rdata,
    output logic [BUS_WIDTH-1:0]            s_ram_waddr,
    output logic [DATA_WIDTH-1:0]           s_ram_wdata,
    output logic [WEN_WIDTH-1:0]            s_ram_wen,
    output logic                            cfg_valid,
    output logic [CFG_WORDS*DATA_WIDTH-1:0] cfg_word,
    output logic                            secure_debug_disable,
    output logic                            pgm_lock
);

    localparam int unsigned TmrMax = (PGM_PULSE > RD_LAT) ? PGM_PULSE : RD_LAT;
    localparam int unsigned TmrW   = $clog2(TmrMax + 1);
    localparam int unsigned IdxW   = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;

    otpc_state_e state_q, state_d;

    logic [IdxW-1:0]                 idx_q, idx_d;
    logic [CFG_WORDS*DATA_WIDTH-1:0] cfg_q, cfg_d;
    logic                            cfg_valid_q, cfg_valid_d;
    logic [BUS_WIDTH-1:0]            addr_q, addr_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic                            done_q, done_d;
    logic                            err_q, err_d;

    logic            tmr_load;
    logic [TmrW-1:0] tmr_val;
    logic            tmr_zero;
    logic            lock;
    logic            last_word;
    logic            pgm_accept;

    assign lock       = cfg_q[OTP_CFG_LOCK_BIT];
    assign last_word  = (idx_q == IdxW'(CFG_WORDS - 1));
    assign pgm_accept = pgm_req && cfg_valid_q && !lock;

    otprom_ctrl_timer #(
        .Width(TmrW)
    ) u_timer (
        .clk_i     (clk),
        .rst_ni    (resetn),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .zero_o    (tmr_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StLdIssue;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and timer loads. Timer loads N-1 on entry so a wait state lasts N cycles.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state_q)
            StLdIssue: begin
                state_d  = StLdWait;
                tmr_load = 1'b1;
                tmr_val  = TmrW'(RD_LAT - 1);
            end
            StLdWait: begin
                if (tmr_zero) begin
                    state_d = last_word ? StIdle : StLdIssue;
                end
            end
            StIdle: begin
                if (pgm_accept) begin
                    state_d  = StPgmWr;
                    tmr_load = 1'b1;
                    tmr_val  = TmrW'(PGM_PULSE - 1);
                end
            end
            StPgmWr: begin
                if (tmr_zero) begin
                    state_d = StVfIssue;
                end
            end
            StVfIssue: begin
                state_d  = StVfWait;
                tmr_load = 1'b1;
                tmr_val  = TmrW'(RD_LAT - 1);
            end
            StVfWait: begin
                if (tmr_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StLdIssue;
        endcase
    end

    // Outputs to the OTPROM and CPU.
    always_comb begin
        s_ram_ren   = 1'b0;
        s_ram_raddr = CFG_BASE + BUS_WIDTH'(idx_q);
        s_ram_waddr = addr_q;
        s_ram_wdata = data_q;
        s_ram_wen   = '0;
        m_ram_ready = 1'b0;
        pgm_busy    = 1'b1;
        unique case (state_q)
            StLdIssue: begin
                s_ram_ren = 1'b1;
            end
            StIdle: begin
                s_ram_raddr = m_ram_raddr;
                s_ram_ren   = m_ram_ren;
                m_ram_ready = 1'b1;
                pgm_busy    = 1'b0;
            end
            StPgmWr: begin
                // Gated by resetn so the burn pulse stops in the very cycle reset asserts.
                s_ram_wen = resetn ? '1 : '0;
            end
            StVfIssue: begin
                s_ram_ren   = 1'b1;
                s_ram_raddr = addr_q;
            end
            default: ;
        endcase
    end

    // Datapath: shadow load, burn latches and completion pulses.
    always_comb begin
        idx_d       = idx_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            StLdWait: begin
                if (tmr_zero) begin
                    cfg_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = s_ram_rdata;
                    if (last_word) begin
                        cfg_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            StIdle: begin
                if (pgm_accept) begin
                    addr_d = pgm_addr;
                    data_d = pgm_data;
                end else if (pgm_req) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
            StVfWait: begin
                if (tmr_zero) begin
                    done_d = 1'b1;
                    err_d  = ((s_ram_rdata & data_q) != data_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            idx_q       <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign m_ram_rdata          = s_ram_rdata;
    assign pgm_done             = done_q;
    assign pgm_err              = err_q;
    assign cfg_valid            = cfg_valid_q;
    assign cfg_word             = cfg_q;
    assign secure_debug_disable = cfg_q[OTP_CFG_SDD_BIT];
    assign pgm_lock             = lock;

endmodule

// File: tb/tb_otprom_ctrl.sv
// Self-checking bench for otprom_ctrl with a behavioural OTPROM model (1-cycle read
// latency, burns OR bits in, optional stuck-unburnable mask). Completions and CPU read
// data are checked by a monitor against expectation queues filled by the stimulus.
module tb_otprom_ctrl;
    import otprom_ctrl_pkg::*;

    localparam int unsigned CfgWords = 4;
    localparam int unsigned DW       = DATA_WIDTH;
    localparam int unsigned BW       = BUS_WIDTH;

    logic                     clk;
    logic                     resetn;
    logic [BW-1:0]            m_ram_raddr;
    logic                     m_ram_ren;
    logic [DW-1:0]            m_ram_rdata;
    logic                     m_ram_ready;
    logic                     pgm_req;
    logic [BW-1:0]            pgm_addr;
    logic [DW-1:0]            pgm_data;
    logic                     pgm_busy;
    logic                     pgm_done;
    logic                     pgm_err;
    logic [BW-1:0]            s_ram_raddr;
    logic                     s_ram_ren;
    logic [DW-1:0]            s_ram_rdata;
    logic [BW-1:0]            s_ram_waddr;
    logic [DW-1:0]            s_ram_wdata;
    logic [WEN_WIDTH-1:0]     s_ram_wen;
    logic                     cfg_valid;
    logic [CfgWords*DW-1:0]   cfg_word;
    logic                     secure_debug_disable;
    logic                     pgm_lock;

    otprom_ctrl dut (
        .clk                 (clk),
        .resetn              (resetn),
        .m_ram_raddr         (m_ram_raddr),
        .m_ram_ren           (m_ram_ren),
        .m_ram_rdata         (m_ram_rdata),
        .m_ram_ready         (m_ram_ready),
        .pgm_req             (pgm_req),
        .pgm_addr            (pgm_addr),
        .pgm_data            (pgm_data),
        .pgm_busy            (pgm_busy),
        .pgm_done            (pgm_done),
        .pgm_err             (pgm_err),
        .s_ram_raddr         (s_ram_raddr),
        .s_ram_ren           (s_ram_ren),
        .s_ram_rdata         (s_ram_rdata),
        .s_ram_waddr         (s_ram_waddr),
        .s_ram_wdata         (s_ram_wdata),
        .s_ram_wen           (s_ram_wen),
        .cfg_valid           (cfg_valid),
        .cfg_word            (cfg_word),
        .secure_debug_disable(secure_debug_disable),
        .pgm_lock            (pgm_lock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;
    int wen_cnt  = 0;
    int vren_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // OTPROM model plus backdoor port used by the stimulus.
    logic [DW-1:0] mem [0:(1<<BW)-1];
    logic [DW-1:0] ignore_mask;
    logic          bd_clr, bd_we;
    logic [BW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_clr) begin
            for (int i = 0; i < (1 << BW); i++) mem[i] <= '0;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (s_ram_wen == '1) begin
            mem[s_ram_waddr] <= mem[s_ram_waddr] | (s_ram_wdata & ~ignore_mask);
        end
        if (s_ram_ren) s_ram_rdata <= mem[s_ram_raddr];
    end

    always @(negedge clk) begin
        if (s_ram_wen != '0) wen_cnt <= wen_cnt + 1;
        if (s_ram_ren && pgm_busy) vren_cnt <= vren_cnt + 1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard.
    logic          exp_err_q [$];
    logic [DW-1:0] exp_rd_q  [$];
    bit            rd_pending = 1'b0;

    always @(negedge clk) begin
        if (rd_pending) begin
            check("rd_expected", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) check("rd_data", m_ram_rdata, exp_rd_q.pop_front());
        end
        rd_pending = m_ram_ren && m_ram_ready;
        if (pgm_done) begin
            check("done_expected", exp_err_q.size() != 0, 1);
            if (exp_err_q.size() != 0) check("done_err", pgm_err, exp_err_q.pop_front());
        end
    end

    task automatic poke(input logic [BW-1:0] a, input logic [DW-1:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1;
        bd_we   = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, output bit ok, output bit prev_busy);
        bit pb;
        ok        = 1'b0;
        lat       = 0;
        prev_busy = 1'b0;
        pb        = pgm_busy;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pgm_done) begin
                ok        = 1'b1;
                lat       = cyc - t0;
                prev_busy = pb;
                break;
            end
            pb = pgm_busy;
        end
    endtask

    task automatic reload();
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 7) begin
                @(negedge clk);
                check("reload_valid_c7", cfg_valid, 0);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int lat;
        bit ok, pb;
        int w0, r0;
        resetn      = 1'b0;
        m_ram_raddr = '0;
        m_ram_ren   = 1'b0;
        pgm_req     = 1'b0;
        pgm_addr    = '0;
        pgm_data    = '0;
        ignore_mask = '0;
        bd_we       = 1'b0;
        bd_addr     = '0;
        bd_data     = '0;
        bd_clr      = 1'b1;
        step();
        bd_clr = 1'b0;
        poke('h10, 32'h1);
        poke('h11, 32'h0);
        poke('h12, 32'hA5);
        poke('h13, 32'h3C);
        poke('h40, 32'hDEADBEEF);

        // Reset state.
        @(negedge clk);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_cfg_word", cfg_word, 0);
        check("rst_sdd", secure_debug_disable, 0);
        check("rst_lock", pgm_lock, 0);
        check("rst_busy", pgm_busy, 1);
        check("rst_done", pgm_done, 0);
        check("rst_err", pgm_err, 0);
        check("rst_wen", s_ram_wen, 0);
        check("rst_ren", s_ram_ren, 1);
        check("rst_raddr", s_ram_raddr, 'h10);
        check("rst_ready", m_ram_ready, 0);

        // Boot load with a CPU read held from cycle 2.
        step();
        resetn = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) begin
                exp_rd_q.push_back(32'hDEADBEEF);
                m_ram_raddr = 'h40;
                m_ram_ren   = 1'b1;
            end
            @(negedge clk);
            check("ld_cfg_valid", cfg_valid, (k == 8));
            if (k >= 2) check("ld_ready", m_ram_ready, (k == 8));
            if ((k % 2) == 0 && k < 8) begin
                check("ld_ren", s_ram_ren, 1);
                check("ld_raddr", s_ram_raddr, 'h10 + k / 2);
            end
        end
        check("ld_cfg_word", cfg_word, {32'h3C, 32'hA5, 32'h0, 32'h1});
        check("ld_sdd", secure_debug_disable, 1);
        check("ld_lock", pgm_lock, 0);
        check("idle_busy", pgm_busy, 0);
        step();
        m_ram_ren = 1'b0;
        @(negedge clk);

        // Good burn, plus a request while busy that must be dropped.
        w0 = wen_cnt;
        r0 = vren_cnt;
        step();
        pgm_req  = 1'b1;
        pgm_addr = 'h20;
        pgm_data = 32'h0F;
        exp_err_q.push_back(1'b0);
        t0 = cyc;
        step();
        pgm_req = 1'b0;
        step();
        pgm_req  = 1'b1;
        pgm_addr = 'h30;
        pgm_data = 32'h1;
        step();
        pgm_req = 1'b0;
        wait_done(lat, ok, pb);
        check("burn_done_seen", ok, 1);
        check("burn_latency", lat, 11);
        check("burn_busy_at_done", pgm_busy, 0);
        check("burn_wen_cycles", wen_cnt - w0, 8);
        check("burn_verify_reads", vren_cnt - r0, 1);
        check("burn_mem", mem['h20], 32'h0F);
        check("dropped_req_mem", mem['h30], 0);

        // Verify failure, with a CPU read in the same IDLE cycle as the request.
        step();
        ignore_mask = 32'h04;
        exp_rd_q.push_back(32'hDEADBEEF);
        m_ram_raddr = 'h40;
        m_ram_ren   = 1'b1;
        pgm_req     = 1'b1;
        pgm_addr    = 'h21;
        pgm_data    = 32'h04;
        exp_err_q.push_back(1'b1);
        t0 = cyc;
        @(negedge clk);
        check("rd_with_req_ready", m_ram_ready, 1);
        step();
        m_ram_ren = 1'b0;
        pgm_req   = 1'b0;
        wait_done(lat, ok, pb);
        check("vf_done_seen", ok, 1);
        check("vf_latency", lat, 11);
        check("vf_busy_before", pb, 1);
        check("vf_busy_at_done", pgm_busy, 0);
        ignore_mask = '0;

        // Reset during the 3rd PGM_WR cycle of a burn to config word 2.
        @(negedge clk);
        w0 = wen_cnt;
        step();
        pgm_req  = 1'b1;
        pgm_addr = 'h12;
        pgm_data = 32'h100;
        step();
        pgm_req = 1'b0;
        step();
        step();
        resetn = 1'b0;
        @(negedge clk);
        check("abort_wen", s_ram_wen, 0);
        check("abort_busy", pgm_busy, 1);
        check("abort_wen_cycles", wen_cnt - w0, 2);
        step();
        @(negedge clk);
        check("abort_no_done", pgm_done, 0);
        reload();
        check("reload_valid", cfg_valid, 1);
        check("reload_cfg_word", cfg_word, {32'h3C, 32'h1A5, 32'h0, 32'h1});

        // Locked part: burn is rejected on the next cycle with no write.
        poke('h10, 32'h2);
        resetn = 1'b0;
        step();
        step();
        reload();
        check("lock_valid", cfg_valid, 1);
        check("lock_bit", pgm_lock, 1);
        check("lock_sdd", secure_debug_disable, 0);
        w0 = wen_cnt;
        step();
        pgm_req  = 1'b1;
        pgm_addr = 'h22;
        pgm_data = 32'h1;
        exp_err_q.push_back(1'b1);
        @(negedge clk);
        check("lock_req_done_early", pgm_done, 0);
        step();
        pgm_req = 1'b0;
        @(negedge clk);
        check("lock_done", pgm_done, 1);
        check("lock_err", pgm_err, 1);
        check("lock_busy", pgm_busy, 0);
        for (int i = 0; i < 4; i++) step();
        @(negedge clk);
        check("lock_no_wen", wen_cnt - w0, 0);
        check("lock_mem", mem['h22], 0);

        check("queues_drained", exp_err_q.size() + exp_rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
